// File: rtl/fp_norm_pack.sv
// Normalize/pack stage of the single-precision add/sub datapath: turns the
// mantissa result word and aligned exponent into a packed IEEE-754 value.
module fp_norm_pack #(
    parameter int EXP_W  = 8,
    parameter int FRAC_W = 23
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [FRAC_W+3:0]         in_res,
    input  logic [EXP_W-1:0]          in_exp,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [EXP_W+FRAC_W:0]     out_fp,
    output logic                      out_zero,
    output logic                      out_ovf,
    output logic                      out_unf
);

    typedef enum logic [1:0] {IDLE, NORM, DONE} state_t;

    // One extra exponent bit keeps the increment/decrement compares exact.
    localparam logic [EXP_W:0] EXP_MAX = {1'b0, {EXP_W{1'b1}}};
    localparam logic [EXP_W:0] EXP_ONE = {{EXP_W{1'b0}}, 1'b1};

    state_t              state;
    logic                r_zero;
    logic                r_sign;
    logic                r_cout;
    logic [FRAC_W:0]     r_sum;
    logic [EXP_W:0]      r_exp;
    logic [EXP_W:0]      exp_inc;
    logic [EXP_W+FRAC_W:0] inf_fp;

    assign exp_inc = r_exp + 1'b1;
    assign inf_fp  = {r_sign, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};

    // Every NORM rule except the left shift finishes the operation, so
    // DONE/out_valid are the NORM defaults and the shift branch overrides them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out_fp    <= '0;
            out_zero  <= 1'b0;
            out_ovf   <= 1'b0;
            out_unf   <= 1'b0;
            r_zero    <= 1'b0;
            r_sign    <= 1'b0;
            r_cout    <= 1'b0;
            r_sum     <= '0;
            r_exp     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        r_zero   <= in_res[FRAC_W+3];
                        r_sign   <= in_res[FRAC_W+2];
                        r_cout   <= in_res[FRAC_W+1];
                        r_sum    <= in_res[FRAC_W:0];
                        r_exp    <= {1'b0, in_exp};
                        in_ready <= 1'b0;
                        state    <= NORM;
                    end
                end
                NORM: begin
                    state     <= DONE;
                    out_valid <= 1'b1;
                    if (r_zero || (!r_cout && r_sum == '0)) begin
                        out_fp   <= '0;
                        out_zero <= 1'b1;
                    end else if (r_exp == EXP_MAX) begin
                        out_fp  <= inf_fp;
                        out_ovf <= 1'b1;
                    end else if (r_cout) begin
                        if (exp_inc == EXP_MAX) begin
                            out_fp  <= inf_fp;
                            out_ovf <= 1'b1;
                        end else begin
                            out_fp <= {r_sign, exp_inc[EXP_W-1:0], r_sum[FRAC_W:1]};
                        end
                    end else if (r_exp == '0) begin
                        out_fp   <= '0;
                        out_zero <= 1'b1;
                        out_unf  <= 1'b1;
                    end else if (r_sum[FRAC_W]) begin
                        out_fp <= {r_sign, r_exp[EXP_W-1:0], r_sum[FRAC_W-1:0]};
                    end else if (r_exp == EXP_ONE) begin
                        // Shifting further would need a denormal; flush instead.
                        out_fp   <= '0;
                        out_zero <= 1'b1;
                        out_unf  <= 1'b1;
                    end else begin
                        r_sum     <= r_sum << 1;
                        r_exp     <= r_exp - 1'b1;
                        state     <= NORM;
                        out_valid <= 1'b0;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        out_zero  <= 1'b0;
                        out_ovf   <= 1'b0;
                        out_unf   <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fp_norm_pack.sv
// Self-checking bench for fp_norm_pack: directed vector table, hand-written
// backpressure/reset sequences, and random operations against a value model.
module tb_fp_norm_pack;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [26:0] in_res;
    logic [7:0]  in_exp;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_fp;
    logic        out_zero;
    logic        out_ovf;
    logic        out_unf;

    int checks = 0;
    int errors = 0;

    fp_norm_pack #(.EXP_W(8), .FRAC_W(23)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_res(in_res), .in_exp(in_exp),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_fp(out_fp), .out_zero(out_zero), .out_ovf(out_ovf), .out_unf(out_unf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        bit          z;
        bit          s;
        bit          c;
        logic [23:0] sum;
        logic [7:0]  e;
        logic [31:0] fp;
        logic [2:0]  flags;
        int          lat;
    } vec_t;

    typedef struct {
        logic [31:0] fp;
        logic [2:0]  flags;
        int          lat;
    } result_t;

    // Value-level reference: the shift count comes from the leading-one position.
    function automatic result_t refModel(bit z, bit s, bit c, int unsigned sum, int unsigned e);
        result_t r;
        int p;
        int k;
        r.fp = 32'h0;
        r.flags = 3'b000;
        r.lat = 1;
        if (z || (!c && sum == 0)) begin
            r.flags = 3'b100;
        end else if (e == 255) begin
            r.fp = {s, 8'hFF, 23'h0};
            r.flags = 3'b010;
        end else if (c) begin
            if (e + 1 == 255) begin
                r.fp = {s, 8'hFF, 23'h0};
                r.flags = 3'b010;
            end else begin
                r.fp = {s, 8'(e + 1), 23'(sum >> 1)};
            end
        end else if (e == 0) begin
            r.flags = 3'b101;
        end else begin
            p = 0;
            for (int b = 0; b < 24; b++) if (sum[b]) p = b;
            k = 23 - p;
            if (int'(e) - k >= 1) begin
                r.fp = {s, 8'(int'(e) - k), 23'(sum << k)};
                r.lat = 1 + k;
            end else begin
                r.flags = 3'b101;
                r.lat = int'(e);
            end
        end
        return r;
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Presents one input, lets it be accepted, then waits (bounded) for out_valid.
    task automatic applyStimulus(input bit z, input bit s, input bit c, input logic [23:0] sum,
                                 input logic [7:0] e, output logic [31:0] fp,
                                 output logic [2:0] fl, output int lat);
        in_res   = {z, s, c, sum};
        in_exp   = e;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_res   = 27'($urandom);
        in_exp   = 8'($urandom);
        lat = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            lat++;
            if (out_valid) break;
        end
        fp = out_fp;
        fl = {out_zero, out_ovf, out_unf};
    endtask

    task automatic releaseResult(input string name);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        checkOutput({name, ".drain"}, {62'h0, out_valid, in_ready}, 64'h1);
    endtask

    task automatic runCase(input string name, input bit z, input bit s, input bit c,
                           input logic [23:0] sum, input logic [7:0] e,
                           input logic [31:0] xfp, input logic [2:0] xfl, input int xlat);
        logic [31:0] fp;
        logic [2:0]  fl;
        int          lat;
        applyStimulus(z, s, c, sum, e, fp, fl, lat);
        checkOutput({name, ".fp"}, {32'h0, fp}, {32'h0, xfp});
        checkOutput({name, ".flags"}, {61'h0, fl}, {61'h0, xfl});
        checkOutput({name, ".lat"}, 64'(lat), 64'(xlat));
        releaseResult(name);
    endtask

    vec_t vecs[$];

    initial begin
        logic [31:0] fp0;
        logic [2:0]  fl0;
        int          lat;
        bit          sawValid;
        result_t     r;

        vecs.push_back('{"norm",      0, 0, 0, 24'h800000, 8'h7F, 32'h3F800000, 3'b000, 1});
        vecs.push_back('{"carry",     0, 0, 1, 24'h000000, 8'h7F, 32'h40000000, 3'b000, 1});
        vecs.push_back('{"carryovf",  0, 1, 1, 24'h000000, 8'hFE, 32'hFF800000, 3'b010, 1});
        vecs.push_back('{"shift1",    0, 0, 0, 24'h400000, 8'h80, 32'h3F800000, 3'b000, 2});
        vecs.push_back('{"shift23",   0, 0, 0, 24'h000001, 8'h96, 32'h3F800000, 3'b000, 24});
        vecs.push_back('{"zeroflag",  1, 1, 0, 24'h123456, 8'h40, 32'h00000000, 3'b100, 1});
        vecs.push_back('{"unf",       0, 0, 0, 24'h000001, 8'h05, 32'h00000000, 3'b101, 5});
        vecs.push_back('{"expmax",    0, 0, 0, 24'h800000, 8'hFF, 32'h7F800000, 3'b010, 1});
        vecs.push_back('{"exp0",      0, 1, 0, 24'h800000, 8'h00, 32'h00000000, 3'b101, 1});
        vecs.push_back('{"sumzero",   0, 1, 0, 24'h000000, 8'h40, 32'h00000000, 3'b100, 1});
        vecs.push_back('{"minnorm",   0, 0, 0, 24'h400000, 8'h02, 32'h00800000, 3'b000, 2});
        vecs.push_back('{"carrytrunc",0, 0, 1, 24'hFFFFFF, 8'h7F, 32'h407FFFFF, 3'b000, 1});
        vecs.push_back('{"carryexp0", 0, 0, 1, 24'h000002, 8'h00, 32'h00800001, 3'b000, 1});

        rst_n = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        in_res = '0;
        in_exp = '0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset.state", {28'h0, out_fp, in_ready, out_valid, out_zero, out_ovf, out_unf},
                    {28'h0, 32'h0, 5'b10000});
        rst_n = 1'b1;
        @(posedge clk); #1;
        checkOutput("reset.idle", {62'h0, in_ready, out_valid}, 64'h2);

        foreach (vecs[i])
            runCase(vecs[i].name, vecs[i].z, vecs[i].s, vecs[i].c, vecs[i].sum, vecs[i].e,
                    vecs[i].fp, vecs[i].flags, vecs[i].lat);

        // Backpressure: result must hold while a new input waits unaccepted.
        applyStimulus(0, 1, 1, 24'h000000, 8'hFE, fp0, fl0, lat);
        checkOutput("bp.first", {29'h0, fl0, fp0}, {29'h0, 3'b010, 32'hFF800000});
        in_res = {1'b0, 1'b0, 1'b0, 24'h800000};
        in_exp = 8'h7F;
        in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            checkOutput("bp.hold", {27'h0, out_valid, in_ready, out_zero, out_ovf, out_unf, out_fp},
                        {27'h0, 2'b10, fl0, fp0});
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        checkOutput("bp.release", {62'h0, out_valid, in_ready}, 64'h1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        checkOutput("bp.accept", {63'h0, in_ready}, 64'h0);
        sawValid = 1'b0;
        for (int i = 0; i < 40 && !sawValid; i++) begin
            @(posedge clk); #1;
            sawValid = out_valid;
        end
        checkOutput("bp.next", {31'h0, sawValid, out_fp}, {31'h0, 1'b1, 32'h3F800000});
        releaseResult("bp");

        // Reset in the middle of a long normalization abandons it.
        in_res = {1'b0, 1'b0, 1'b0, 24'h000001};
        in_exp = 8'h96;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        checkOutput("midreset", {28'h0, out_fp, in_ready, out_valid, out_zero, out_ovf, out_unf},
                    {28'h0, 32'h0, 5'b10000});
        #3;
        rst_n = 1'b1;
        sawValid = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk); #1;
            if (out_valid) sawValid = 1'b1;
        end
        checkOutput("midreset.noresult", {63'h0, sawValid}, 64'h0);
        runCase("postreset", 0, 0, 0, 24'h800000, 8'h7F, 32'h3F800000, 3'b000, 1);

        // Random operations, biased toward exponent and shift-count corners.
        for (int i = 0; i < 300; i++) begin
            bit          z;
            bit          s;
            bit          c;
            logic [23:0] sum;
            logic [7:0]  e;
            int          sel;
            z = ($urandom_range(0, 15) == 0);
            s = 1'($urandom);
            c = ($urandom_range(0, 3) == 0);
            sum = 24'($urandom) >> $urandom_range(0, 24);
            sel = $urandom_range(0, 9);
            case (sel)
                0: e = 8'h00;
                1: e = 8'hFF;
                2: e = 8'hFE;
                3: e = 8'($urandom_range(1, 24));
                default: e = 8'($urandom_range(0, 255));
            endcase
            r = refModel(z, s, c, int'(sum), int'(e));
            runCase($sformatf("rand%0d", i), z, s, c, sum, e, r.fp, r.flags, r.lat);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fp_norm_pack.md
Name: fp_norm_pack

Overview:
- Back end of the single-precision add/sub datapath. Consumes the mantissa add/sub result word and the aligned (larger) exponent, and produces a packed IEEE-754 single result.
- Work per operation:
  - normalizes the result iteratively, one left shift per cycle, or a single right shift on carry;
  - flushes underflow to zero;
  - saturates overflow to infinity;
  - packs sign, exponent and fraction into 32 bits.
- Valid/ready on both sides; one operation in flight.

Parameters:
- EXP_W, 8, exponent width.
- FRAC_W, 23, stored fraction width. The internal significand is FRAC_W+1 bits.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  input word valid.
- in_ready  out  1  block can accept an input.
- in_res  in  FRAC_W+4  {zero, sign, cout, sum[FRAC_W:0]}. zero = add/sub reported a zero result; sign = result sign; cout = adder carry; sum includes the hidden-bit position.
- in_exp  in  EXP_W  biased exponent of the aligned operands.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts the result.
- out_fp  out  1+EXP_W+FRAC_W  packed {sign, exp, frac}.
- out_zero  out  1  result is zero (includes flush).
- out_ovf  out  1  overflow, result is infinity.
- out_unf  out  1  underflow, flushed to zero.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; in_ready=1; out_valid=0; out_fp=0; all flags 0; internal registers 0.
  - Reset mid-operation abandons the operation; no result is produced.
- States: IDLE, NORM, DONE.
- IDLE:
  - in_ready=1.
  - On the edge with in_valid&&in_ready: capture sign, cout, sum, exp, and zero flag into registers, then go to NORM.
- NORM (in_ready=0). Evaluated once per cycle, first matching rule wins:
  1. zero=1, or (cout=0 and sum=0): result +0 (sign forced 0), out_zero=1. Go to DONE.
  2. in_exp captured as all-ones: infinity with the captured sign, out_ovf=1. Go to DONE.
  3. cout=1: exp+1.
     - If the new exp is all-ones: infinity, out_ovf=1.
     - Otherwise the significand is {1, sum[FRAC_W:1]} (truncate). Pack it.
     - Go to DONE.
  4. exp=0 with nonzero sum: flush to +0, out_unf=1, out_zero=1. Go to DONE.
  5. sum[FRAC_W]=1: pack {sign, exp, sum[FRAC_W-1:0]}. Go to DONE.
  6. exp=1, sum[FRAC_W]=0: flush to +0, out_unf=1, out_zero=1. Go to DONE. Denormals are never produced.
  7. Otherwise: sum <<= 1, exp -= 1. Stay in NORM.
- Rounding: truncation only. No sticky bits.
- Infinity encoding: exp all-ones, frac 0.
- DONE:
  - out_valid=1; out_fp and flags are registered and held stable while out_ready=0.
  - On the edge with out_valid&&out_ready: clear out_valid and flags, go to IDLE.
  - out_fp holds its last value until the next result.
- Latency from the accept edge to out_valid high:
  - 1 cycle for the zero, carry, special and already-normalized cases;
  - 1+n cycles for n left shifts; maximum 1+FRAC_W.
- Throughput: in_ready is low from accept until the cycle after the output handshake. No input is accepted in the same cycle as the output handshake.
- Back-to-back: after DONE→IDLE, a new accept is possible on the next edge.
- in_res and in_exp are ignored outside the accept edge.
- Widths: exp arithmetic is EXP_W+1 bits internally so the overflow and underflow compares are exact.

Test Plan:
- Normalized input, no carry: in_res={0,0,0,24'h800000}, in_exp=8'h7F → out_fp=32'h3F800000, 1 cycle after accept, all flags 0.
- Carry: in_res={0,0,1,24'h000000}, in_exp=8'h7F → 32'h40000000 in 1 cycle. Repeat with in_exp=8'hFE and sign=1 → 32'hFF800000, out_ovf=1.
- Left shift: sum=24'h400000, in_exp=8'h80 → 32'h3F800000 in 2 cycles. Then sum=24'h000001, in_exp=8'h96 → 32'h3F800000 in 24 cycles.
- Zero and underflow:
  - zero flag=1 with sign=1 → 32'h00000000, out_zero=1, 1 cycle.
  - sum=24'h000001, in_exp=8'h05 → 32'h00000000, out_unf=1, out_zero=1, after 5 cycles (4 shifts, then flush).
- Backpressure: hold out_ready=0 for 10 cycles after out_valid → out_fp/flags stable, in_ready=0. Raise out_ready → out_valid=0 next cycle, in_ready=1, next input accepted on the following edge.
- Reset mid-NORM: start sum=24'h000001, assert rst_n=0 after 3 cycles → immediate in_ready=1, out_valid=0, out_fp=0. No result emitted after release.
